// File: rtl/kanagawa_reorder_slot_allocator.sv
// Reorder-buffer slot ID allocator with in-order release and flush/drain FSM.
// Issued IDs carry a wrap bit above the slot index so the consumer can tell
// iterations apart. Presents a show-ahead FIFO read interface for IDs.
// Optional macro KANAGAWA_REORDER_ALLOC_CHECK_EN enables sticky overflow and
// underflow flags plus simulation errors; without it both flags are tied to 0.
// The release port is named release_req because "release" is a reserved word.
module kanagawa_reorder_slot_allocator #(
  parameter int unsigned LOG_DEPTH       = 5,
  parameter int unsigned SLOT_ID_WIDTH   = LOG_DEPTH + 1,
  parameter int unsigned MAX_OUTSTANDING = 2 ** LOG_DEPTH
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     alloc_rdreq,
  output logic                     alloc_empty,
  output logic [SLOT_ID_WIDTH-1:0] alloc_slot_id,
  input  logic                     release_req,
  output logic [LOG_DEPTH:0]       outstanding,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     overflow_out,
  output logic                     underflow_out
);

  localparam int unsigned OutW = LOG_DEPTH + 1;
  localparam logic [OutW-1:0] MaxOut = OutW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e                   state_q, state_d;
  logic [SLOT_ID_WIDTH-1:0] head_q, head_d;
  logic [SLOT_ID_WIDTH-1:0] tail_q, tail_d;
  logic [SLOT_ID_WIDTH-1:0] diff_d;
  logic [OutW-1:0]          outstanding_q, outstanding_d;
  logic                     alloc_empty_q, alloc_empty_d;
  logic                     flush_done_q;
  logic                     alloc_ok, rel_ok;

  assign alloc_ok = alloc_rdreq && !alloc_empty_q;
  assign rel_ok   = release_req && (outstanding_q != '0);

  // Next-state for counters and FSM; empty is derived from next-state values
  // so a release at the full boundary frees a slot without a bubble.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    state_d = state_q;
    if (alloc_ok) head_d = head_q + 1'b1;
    if (rel_ok)   tail_d = tail_q + 1'b1;
    diff_d        = head_d - tail_d;
    outstanding_d = OutW'(diff_d);
    unique case (state_q)
      StRun:   if (flush_req) state_d = StDrain;
      StDrain: if (outstanding_q == '0) state_d = StDone;
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
    alloc_empty_d = (state_d != StRun) || (outstanding_d == MaxOut);
  end

  // State registers with synchronous reset; flush_done is a registered pulse.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= StRun;
      head_q        <= '0;
      tail_q        <= '0;
      outstanding_q <= '0;
      alloc_empty_q <= 1'b1;
      flush_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      outstanding_q <= outstanding_d;
      alloc_empty_q <= alloc_empty_d;
      flush_done_q  <= (state_d == StDone);
    end
  end

  assign alloc_slot_id = head_q;
  assign outstanding   = outstanding_q;
  assign alloc_empty   = alloc_empty_q;
  assign flush_done    = flush_done_q;

`ifdef KANAGAWA_REORDER_ALLOC_CHECK_EN
  logic overflow_q, underflow_q;

  // Sticky misuse flags, cleared only by reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (alloc_rdreq && alloc_empty_q) begin
        overflow_q <= 1'b1;
        $error("slot allocator: alloc_rdreq while alloc_empty");
      end
      if (release_req && (outstanding_q == '0)) begin
        underflow_q <= 1'b1;
        $error("slot allocator: release with nothing outstanding");
      end
    end
  end

  assign overflow_out  = overflow_q;
  assign underflow_out = underflow_q;
`else
  assign overflow_out  = 1'b0;
  assign underflow_out = 1'b0;
`endif

endmodule

// File: tb/tb_kanagawa_reorder_slot_allocator.sv
// Directed bench for kanagawa_reorder_slot_allocator (LOG_DEPTH=5 defaults).
module tb_kanagawa_reorder_slot_allocator;

  logic       clock = 1'b0;
  logic       rst;
  logic       alloc_rdreq;
  logic       alloc_empty;
  logic [5:0] alloc_slot_id;
  logic       release_req;
  logic [5:0] outstanding;
  logic       flush_req;
  logic       flush_done;
  logic       overflow_out;
  logic       underflow_out;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef KANAGAWA_REORDER_ALLOC_CHECK_EN
  localparam logic ExpFlag = 1'b1;
`else
  localparam logic ExpFlag = 1'b0;
`endif

  kanagawa_reorder_slot_allocator #(
    .LOG_DEPTH(5)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .alloc_rdreq  (alloc_rdreq),
    .alloc_empty  (alloc_empty),
    .alloc_slot_id(alloc_slot_id),
    .release_req  (release_req),
    .outstanding  (outstanding),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .overflow_out (overflow_out),
    .underflow_out(underflow_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; alloc_rdreq = 1'b0; release_req = 1'b0; flush_req = 1'b0;
    tick(); tick();
    // Reset state
    check("rst_slot", 32'(alloc_slot_id), 32'h0);
    check("rst_empty", 32'(alloc_empty), 32'h1);
    check("rst_out", 32'(outstanding), 32'h0);
    check("rst_fd", 32'(flush_done), 32'h0);
    check("rst_ovf", 32'(overflow_out), 32'h0);
    check("rst_unf", 32'(underflow_out), 32'h0);

    rst = 1'b0;
    tick();
    check("post_rst_empty", 32'(alloc_empty), 32'h0);

    // 32 back-to-back allocs fill the buffer
    alloc_rdreq = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check("fill_slot", 32'(alloc_slot_id), 32'(i));
      tick();
    end
    check("full_empty", 32'(alloc_empty), 32'h1);
    check("full_out", 32'(outstanding), 32'd32);

    // Alloc while full is ignored
    tick();
    alloc_rdreq = 1'b0;
    check("ovf_slot", 32'(alloc_slot_id), 32'h20);
    check("ovf_out", 32'(outstanding), 32'd32);
    check("ovf_flag", 32'(overflow_out), 32'(ExpFlag));

    // Release at full boundary frees a slot next cycle
    release_req = 1'b1;
    tick();
    release_req = 1'b0;
    check("rel_full_empty", 32'(alloc_empty), 32'h0);
    check("rel_full_out", 32'(outstanding), 32'd31);

    alloc_rdreq = 1'b1;
    check("wrap_slot", 32'(alloc_slot_id), 32'h20);
    tick();
    alloc_rdreq = 1'b0;
    check("refull_out", 32'(outstanding), 32'd32);
    check("refull_empty", 32'(alloc_empty), 32'h1);

    release_req = 1'b1;
    tick();
    // Simultaneous alloc+release streams the rest of the ID space
    alloc_rdreq = 1'b1;
    for (int i = 0; i < 31; i++) begin
      check("stream_slot", 32'(alloc_slot_id), 32'h21 + 32'(i));
      tick();
    end
    alloc_rdreq = 1'b0;
    check("wrap0_slot", 32'(alloc_slot_id), 32'h0);
    check("stream_out", 32'(outstanding), 32'd31);

    // Drain to 16, then a simultaneous alloc+release
    for (int i = 0; i < 15; i++) tick();
    check("out16", 32'(outstanding), 32'd16);
    alloc_rdreq = 1'b1;
    tick();
    alloc_rdreq = 1'b0;
    check("simul_out", 32'(outstanding), 32'd16);
    check("simul_slot", 32'(alloc_slot_id), 32'h1);

    // Down to 5 outstanding, then flush
    for (int i = 0; i < 11; i++) tick();
    release_req = 1'b0;
    check("out5", 32'(outstanding), 32'd5);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("drain_empty", 32'(alloc_empty), 32'h1);
    check("drain_fd", 32'(flush_done), 32'h0);
    release_req = 1'b1;
    flush_req = 1'b1;  // ignored while draining
    for (int i = 0; i < 5; i++) begin
      tick();
      flush_req = 1'b0;
      check("drain_rel_fd", 32'(flush_done), 32'h0);
      check("drain_rel_empty", 32'(alloc_empty), 32'h1);
    end
    release_req = 1'b0;
    check("drain_out0", 32'(outstanding), 32'h0);
    tick();
    check("done_fd", 32'(flush_done), 32'h1);
    check("done_empty", 32'(alloc_empty), 32'h1);
    tick();
    check("after_done_fd", 32'(flush_done), 32'h0);
    check("after_done_empty", 32'(alloc_empty), 32'h0);
    check("preserved_slot", 32'(alloc_slot_id), 32'h1);
    alloc_rdreq = 1'b1;
    tick();
    alloc_rdreq = 1'b0;
    check("resume_slot", 32'(alloc_slot_id), 32'h2);
    check("resume_out", 32'(outstanding), 32'h1);

    // Underflow: release with nothing outstanding is ignored
    release_req = 1'b1;
    tick();
    check("rel_to0", 32'(outstanding), 32'h0);
    tick();
    release_req = 1'b0;
    check("unf_out", 32'(outstanding), 32'h0);
    check("unf_flag", 32'(underflow_out), 32'(ExpFlag));

    // Flush with nothing outstanding: done two cycles after request
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("f0_drain_fd", 32'(flush_done), 32'h0);
    check("f0_drain_empty", 32'(alloc_empty), 32'h1);
    tick();
    check("f0_done_fd", 32'(flush_done), 32'h1);
    tick();
    check("f0_run_fd", 32'(flush_done), 32'h0);
    check("f0_run_empty", 32'(alloc_empty), 32'h0);

    // Ten allocs, flush, then reset mid-drain
    alloc_rdreq = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    alloc_rdreq = 1'b0;
    check("out10", 32'(outstanding), 32'd10);
    check("slot12", 32'(alloc_slot_id), 32'd12);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst_out", 32'(outstanding), 32'h0);
    check("mid_rst_slot", 32'(alloc_slot_id), 32'h0);
    check("mid_rst_empty", 32'(alloc_empty), 32'h1);
    check("mid_rst_fd", 32'(flush_done), 32'h0);
    check("mid_rst_ovf", 32'(overflow_out), 32'h0);
    check("mid_rst_unf", 32'(underflow_out), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_mid_fd", 32'(flush_done), 32'h0);
      check("post_mid_empty", 32'(alloc_empty), 32'h0);
    end
    check("post_mid_slot", 32'(alloc_slot_id), 32'h0);
    alloc_rdreq = 1'b1;
    tick();
    alloc_rdreq = 1'b0;
    check("post_mid_next", 32'(alloc_slot_id), 32'h1);
    check("post_mid_out", 32'(outstanding), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kanagawa_reorder_slot_allocator.md
KANAGAWA_REORDER_SLOT_ALLOCATOR -- requirements
Module: kanagawa_reorder_slot_allocator

Interface
REQ-001 The block SHALL have parameter LOG_DEPTH, default 5: log2 of reorder buffer depth; DEPTH = 2**LOG_DEPTH.
REQ-002 The block SHALL have parameter SLOT_ID_WIDTH, default LOG_DEPTH+1: issued ID width; MSB is the wrap (iteration) bit, low LOG_DEPTH bits are the slot index.
REQ-003 The block SHALL have parameter MAX_OUTSTANDING, default DEPTH: allocation limit, legal range 1..DEPTH.
REQ-004 The block SHALL have port clock  in  1  the single clock, rising-edge.
REQ-005 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port alloc_rdreq  in  1  consumes the presented slot ID this cycle.
REQ-007 The block SHALL have port alloc_empty  out  1  no slot ID available; show-ahead FIFO semantics.
REQ-008 The block SHALL have port alloc_slot_id  out  SLOT_ID_WIDTH  next slot ID; valid while alloc_empty=0.
REQ-009 The block SHALL have port release  in  1  one entry popped from the reorder buffer output (in-order retire).
REQ-010 The block SHALL have port outstanding  out  LOG_DEPTH+1  allocated minus released count.
REQ-011 The block SHALL have port flush_req  in  1  single-cycle pulse requesting a drain.
REQ-012 The block SHALL have port flush_done  out  1  single-cycle pulse when the drain completes.
REQ-013 The block SHALL have port overflow_out  out  1  sticky flag: alloc_rdreq while alloc_empty=1.
REQ-014 The block SHALL have port underflow_out  out  1  sticky flag: release while outstanding=0.

Function
REQ-015 The block SHALL keep a head counter and a tail counter, each SLOT_ID_WIDTH bits, each wrapping modulo 2**SLOT_ID_WIDTH; alloc_slot_id = head.
REQ-016 An accepted alloc (alloc_rdreq=1, alloc_empty=0) at cycle N SHALL increment head, visible on alloc_slot_id at N+1.
REQ-017 An accepted release (release=1, outstanding>0) at cycle N SHALL increment tail; outstanding updates at N+1.
REQ-018 outstanding SHALL be registered and equal (head - tail) mod 2**SLOT_ID_WIDTH.
REQ-019 A simultaneous accepted alloc and release SHALL leave outstanding unchanged and advance both counters.
REQ-020 alloc_empty SHALL be registered and computed from next-state values: 1 when next outstanding = MAX_OUTSTANDING, or when the FSM is not in RUN.
REQ-021 Release at the full boundary SHALL deassert alloc_empty at N+1; no bubble cycle is allowed.
REQ-022 alloc_rdreq while alloc_empty=1 SHALL be ignored: head unchanged.
REQ-023 release while outstanding=0 SHALL be ignored: tail unchanged.
REQ-024 The FSM SHALL have states RUN, DRAIN, DONE.
REQ-025 In RUN, a flush_req SHALL move the FSM to DRAIN.
REQ-026 In DRAIN, alloc_empty SHALL be 1 and releases SHALL still be accepted; when outstanding reaches 0 the FSM SHALL move to DONE.
REQ-027 DONE SHALL last one cycle with flush_done=1, then return to RUN; head and tail are preserved so ID sequence continuity holds.
REQ-028 A flush_req with outstanding=0 SHALL give RUN->DRAIN->DONE, with flush_done 2 cycles after flush_req.
REQ-029 A flush_req received in DRAIN or DONE SHALL be ignored.

Reset
REQ-030 While rst=1 the block SHALL hold: head=0, tail=0, outstanding=0, FSM=RUN, alloc_slot_id=0, alloc_empty=1, flush_done=0, overflow_out=0, underflow_out=0.
REQ-031 alloc_empty SHALL deassert in the first cycle after rst deasserts.
REQ-032 Reset asserted mid-operation SHALL abandon all outstanding IDs and any drain in progress; after reset the sequence restarts at ID 0.

Configuration
REQ-033 With macro KANAGAWA_REORDER_ALLOC_CHECK_EN defined, overflow_out and underflow_out SHALL be sticky registers set by the illegal events in REQ-022 and REQ-023, cleared only by rst, and each event SHALL also raise a simulation $error.
REQ-034 Without KANAGAWA_REORDER_ALLOC_CHECK_EN, overflow_out and underflow_out SHALL be tied to 0, no checks SHALL be compiled, and the ignore behaviour of REQ-022 and REQ-023 SHALL remain.

Verification
REQ-035 LOG_DEPTH=5, default MAX_OUTSTANDING: after reset, 32 back-to-back allocs -> IDs 0x00..0x1F in order; alloc_empty=1 and outstanding=32 after the 32nd.
REQ-036 From that full state, one release -> alloc_empty=0 the next cycle; next alloc returns 0x20 (wrap=1, index 0); after 64 total allocs, IDs wrap back to 0x00.
REQ-037 outstanding=16, alloc_rdreq and release in the same cycle -> outstanding stays 16; alloc_slot_id advances by 1.
REQ-038 Full, alloc_rdreq=1 -> alloc_slot_id unchanged; overflow_out=1 with the macro, 0 without; release at outstanding=0 -> underflow_out=1 with the macro.
REQ-039 outstanding=5, flush_req pulse -> alloc_empty=1 immediately after; 5 releases; flush_done pulses exactly once, the cycle after outstanding reaches 0; allocs then resume at the preserved head ID.
REQ-040 outstanding=10 in DRAIN, rst for 1 cycle -> outstanding=0, flush_done never pulses, first post-reset ID is 0x00.
